// File: rtl/kamus_pkg.sv
// Shared kamus pipeline types: the decoded operation set produced by the ID stage.
package kamus_pkg;
    typedef enum logic [5:0] {
        INVALID = 6'd0,
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, ECALL, EBREAK,
        CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI
    } operation_e;
endpackage

// File: rtl/kamus_id_pipe.sv
// kamus_id_pipe: registered RV32I/Zicsr decode stage with a 2-entry skid buffer, load-use
// stall and flush. Define KAMUS_ID_PERF_EN to add the stall/hazard performance counters.
//   state | meaning
//   EMPTY | M and S empty
//   ONE   | M holds the oldest instruction, S empty
//   FULL  | M and S both hold instructions, fetch is stalled
module kamus_id_pipe
    import kamus_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int PC_WIDTH = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                if_valid_i,
    output logic                if_ready_o,
    input  logic [31:0]         instr_i,
    input  logic [PC_WIDTH-1:0] pc_i,
    input  logic                flush_i,
    input  logic                ex_load_valid_i,
    input  logic [4:0]          ex_load_rd_i,
    output logic                id_valid_o,
    input  logic                ex_ready_i,
    output operation_e          op_o,
    output logic [4:0]          rd_addr_o,
    output logic [4:0]          rs1_addr_o,
    output logic [4:0]          rs2_addr_o,
    output logic [XLEN-1:0]     imm_o,
    output logic                imm_used_o,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                illegal_o
`ifdef KAMUS_ID_PERF_EN
    ,
    output logic [31:0]         stall_cnt_o,
    output logic [31:0]         hazard_cnt_o
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z, IMM_SH} imm_sel_e;

    typedef struct packed {
        operation_e          op;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [XLEN-1:0]     imm;
        logic                imm_used;
        logic [PC_WIDTH-1:0] pc;
        logic                illegal;
        logic                rs1_used;
        logic                rs2_used;
    } entry_t;

    entry_t     dec, m_q, m_n, s_q, s_n;
    state_e     state_q, state_n;
    logic       ready_q;
    logic       accept, drain, hazard;
    operation_e dec_op;
    imm_sel_e   dec_sel;
    logic       use_rd, use_rs1, use_rs2;
    logic [6:0] opcode, f7;
    logic [2:0] f3;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];

    always_comb begin
        dec_op  = INVALID;
        dec_sel = IMM_NONE;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            7'b0110111: begin dec_op = LUI;   dec_sel = IMM_U; use_rd = 1'b1; end
            7'b0010111: begin dec_op = AUIPC; dec_sel = IMM_U; use_rd = 1'b1; end
            7'b1101111: begin dec_op = JAL;   dec_sel = IMM_J; use_rd = 1'b1; end
            7'b1100111: begin
                dec_sel = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
                if (f3 == 3'd0) dec_op = JALR;
            end
            7'b1100011: begin
                dec_sel = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
                case (f3)
                    3'd0: dec_op = BEQ;
                    3'd1: dec_op = BNE;
                    3'd4: dec_op = BLT;
                    3'd5: dec_op = BGE;
                    3'd6: dec_op = BLTU;
                    3'd7: dec_op = BGEU;
                    default: ;
                endcase
            end
            7'b0000011: begin
                dec_sel = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
                case (f3)
                    3'd0: dec_op = LB;
                    3'd1: dec_op = LH;
                    3'd2: dec_op = LW;
                    3'd4: dec_op = LBU;
                    3'd5: dec_op = LHU;
                    default: ;
                endcase
            end
            7'b0100011: begin
                dec_sel = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
                case (f3)
                    3'd0: dec_op = SB;
                    3'd1: dec_op = SH;
                    3'd2: dec_op = SW;
                    default: ;
                endcase
            end
            7'b0010011: begin
                dec_sel = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
                case (f3)
                    3'd0: dec_op = ADD;
                    3'd2: dec_op = SLT;
                    3'd3: dec_op = SLTU;
                    3'd4: dec_op = XOR;
                    3'd6: dec_op = OR;
                    3'd7: dec_op = AND;
                    3'd1: if (f7 == 7'h00) begin dec_op = SLL; dec_sel = IMM_SH; end
                    default: begin
                        if (f7 == 7'h00) begin dec_op = SRL; dec_sel = IMM_SH; end
                        else if (f7 == 7'h20) begin dec_op = SRA; dec_sel = IMM_SH; end
                    end
                endcase
            end
            7'b0110011: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: dec_op = ADD;
                        3'd1: dec_op = SLL;
                        3'd2: dec_op = SLT;
                        3'd3: dec_op = SLTU;
                        3'd4: dec_op = XOR;
                        3'd5: dec_op = SRL;
                        3'd6: dec_op = OR;
                        default: dec_op = AND;
                    endcase
                end else if (f7 == 7'h20) begin
                    if (f3 == 3'd0) dec_op = SUB;
                    else if (f3 == 3'd5) dec_op = SRA;
                end
            end
            7'b0001111: if (f3 == 3'd0) dec_op = FENCE;
            7'b1110011: begin
                case (f3)
                    3'd0: begin
                        if (instr_i == 32'h0000_0073) dec_op = ECALL;
                        else if (instr_i == 32'h0010_0073) dec_op = EBREAK;
                    end
                    3'd1: begin dec_op = CSRRW;  use_rd = 1'b1; use_rs1 = 1'b1; end
                    3'd2: begin dec_op = CSRRS;  use_rd = 1'b1; use_rs1 = 1'b1; end
                    3'd3: begin dec_op = CSRRC;  use_rd = 1'b1; use_rs1 = 1'b1; end
                    3'd5: begin dec_op = CSRRWI; use_rd = 1'b1; dec_sel = IMM_Z; end
                    3'd6: begin dec_op = CSRRSI; use_rd = 1'b1; dec_sel = IMM_Z; end
                    3'd7: begin dec_op = CSRRCI; use_rd = 1'b1; dec_sel = IMM_Z; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Unused fields are zeroed so the register-range check and hazard see only real operands.
    always_comb begin
        dec    = '0;
        dec.pc = pc_i;
        dec.op = dec_op;
        if (dec_op == INVALID) begin
            dec.illegal = 1'b1;
        end else begin
            if (use_rd)  dec.rd  = instr_i[11:7];
            if (use_rs1) dec.rs1 = instr_i[19:15];
            if (use_rs2) dec.rs2 = instr_i[24:20];
            dec.rs1_used = use_rs1;
            dec.rs2_used = use_rs2;
            dec.imm_used = (dec_sel != IMM_NONE);
            case (dec_sel)
                IMM_I:   dec.imm = XLEN'($signed(instr_i[31:20]));
                IMM_S:   dec.imm = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
                IMM_B:   dec.imm = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                                  instr_i[11:8], 1'b0}));
                IMM_U:   dec.imm = XLEN'($signed({instr_i[31:12], 12'h000}));
                IMM_J:   dec.imm = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                                  instr_i[30:21], 1'b0}));
                IMM_Z:   dec.imm = XLEN'(instr_i[19:15]);
                IMM_SH:  dec.imm = XLEN'(instr_i[24:20]);
                default: dec.imm = '0;
            endcase
            dec.illegal = (32'(dec.rd) >= NREGS) || (32'(dec.rs1) >= NREGS) ||
                          (32'(dec.rs2) >= NREGS);
        end
    end

    assign hazard = (state_q != EMPTY) && ex_load_valid_i && (ex_load_rd_i != 5'd0) &&
                    ((m_q.rs1_used && (m_q.rs1 == ex_load_rd_i)) ||
                     (m_q.rs2_used && (m_q.rs2 == ex_load_rd_i)));
    assign id_valid_o = (state_q != EMPTY) && !hazard;
    assign accept     = if_valid_i && ready_q;
    assign drain      = id_valid_o && ex_ready_i;

    always_comb begin
        state_n = state_q;
        m_n     = m_q;
        s_n     = s_q;
        if (flush_i) begin
            state_n = EMPTY;
            m_n     = '0;
            s_n     = '0;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin m_n = dec; state_n = ONE; end
                ONE: begin
                    if (accept && drain) m_n = dec;
                    else if (accept) begin s_n = dec; state_n = FULL; end
                    else if (drain) state_n = EMPTY;
                end
                FULL: if (drain) begin m_n = s_q; state_n = ONE; end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            ready_q <= 1'b0;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_n;
            ready_q <= (state_n != FULL);
            m_q     <= m_n;
            s_q     <= s_n;
        end
    end

    assign if_ready_o = ready_q;
    assign op_o       = m_q.op;
    assign rd_addr_o  = m_q.rd;
    assign rs1_addr_o = m_q.rs1;
    assign rs2_addr_o = m_q.rs2;
    assign imm_o      = m_q.imm;
    assign imm_used_o = m_q.imm_used;
    assign pc_o       = m_q.pc;
    assign illegal_o  = m_q.illegal;

`ifdef KAMUS_ID_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o  <= '0;
            hazard_cnt_o <= '0;
        end else begin
            if (id_valid_o && !ex_ready_i) stall_cnt_o <= stall_cnt_o + 32'd1;
            if (hazard) hazard_cnt_o <= hazard_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_kamus_id_pipe.sv
// Scoreboard bench for kamus_id_pipe: an encoder-side model builds each instruction together
// with its expected decode; a negedge monitor tracks the 2-deep FIFO, stalls and flushes.
module tb_kamus_id_pipe;
    import kamus_pkg::*;

    typedef struct {
        operation_e  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic        imm_used;
        logic [31:0] pc;
        logic        illegal, illegal16;
        logic        r1, r2;
    } exp_t;

    localparam operation_e R_OPS [10] = '{ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND};
    localparam logic [2:0] R_F3 [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    localparam operation_e I_OPS [6] = '{ADD, SLT, SLTU, XOR, OR, AND};
    localparam logic [2:0] I_F3 [6] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    localparam operation_e SH_OPS [3] = '{SLL, SRL, SRA};
    localparam operation_e L_OPS [5] = '{LB, LH, LW, LBU, LHU};
    localparam logic [2:0] L_F3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    localparam operation_e S_OPS [3] = '{SB, SH, SW};
    localparam operation_e B_OPS [6] = '{BEQ, BNE, BLT, BGE, BLTU, BGEU};
    localparam logic [2:0] B_F3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    localparam operation_e C_OPS [6] = '{CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI};
    localparam logic [2:0] C_F3 [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

    logic clk = 1'b0, rst = 1'b1;
    logic if_valid = 1'b0, flush = 1'b0, ld_valid = 1'b0, ex_ready = 1'b0;
    logic [31:0] instr = '0, pc = '0;
    logic [4:0]  ld_rd = '0;
    logic if_ready, id_valid, imm_used, illegal;
    operation_e op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, pc_out;
    logic if_ready16, id_valid16, imm_used16, illegal16;
    operation_e op16;
    logic [4:0]  rd16, rs1_16, rs2_16;
    logic [31:0] imm16, pc16;
`ifdef KAMUS_ID_PERF_EN
    logic [31:0] stall_cnt, hazard_cnt, stall_cnt16, hazard_cnt16;
    logic [31:0] stall_m = '0, hazard_m = '0;
`endif

    always #5 clk = ~clk;

    kamus_id_pipe dut (
        .clk_i(clk), .rst_i(rst), .if_valid_i(if_valid), .if_ready_o(if_ready),
        .instr_i(instr), .pc_i(pc), .flush_i(flush), .ex_load_valid_i(ld_valid),
        .ex_load_rd_i(ld_rd), .id_valid_o(id_valid), .ex_ready_i(ex_ready), .op_o(op),
        .rd_addr_o(rd), .rs1_addr_o(rs1), .rs2_addr_o(rs2), .imm_o(imm),
        .imm_used_o(imm_used), .pc_o(pc_out), .illegal_o(illegal)
`ifdef KAMUS_ID_PERF_EN
        , .stall_cnt_o(stall_cnt), .hazard_cnt_o(hazard_cnt)
`endif
    );

    kamus_id_pipe #(.NREGS(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .if_valid_i(if_valid), .if_ready_o(if_ready16),
        .instr_i(instr), .pc_i(pc), .flush_i(flush), .ex_load_valid_i(ld_valid),
        .ex_load_rd_i(ld_rd), .id_valid_o(id_valid16), .ex_ready_i(ex_ready), .op_o(op16),
        .rd_addr_o(rd16), .rs1_addr_o(rs1_16), .rs2_addr_o(rs2_16), .imm_o(imm16),
        .imm_used_o(imm_used16), .pc_o(pc16), .illegal_o(illegal16)
`ifdef KAMUS_ID_PERF_EN
        , .stall_cnt_o(stall_cnt16), .hazard_cnt_o(hazard_cnt16)
`endif
    );

    int   n_checks = 0, n_pass = 0;
    exp_t q[$];
    exp_t cur_exp;
    bit   exp_ready = 1'b0;
    bit   accepted = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    endtask

    function automatic exp_t blank(input logic [31:0] p);
        exp_t e;
        e.op = INVALID; e.rd = '0; e.rs1 = '0; e.rs2 = '0; e.imm = '0; e.imm_used = 1'b0;
        e.pc = p; e.illegal = 1'b0; e.illegal16 = 1'b0; e.r1 = 1'b0; e.r2 = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk(input operation_e o, input int d, input int a, input int b,
                                input logic [31:0] im, input bit used, input bit ill,
                                input bit ill16, input bit r1, input bit r2, input logic [31:0] p);
        exp_t e = blank(p);
        e.op = o; e.rd = 5'(d); e.rs1 = 5'(a); e.rs2 = 5'(b); e.imm = im; e.imm_used = used;
        e.illegal = ill; e.illegal16 = ill16; e.r1 = r1; e.r2 = r2;
        return e;
    endfunction

    function automatic logic [4:0] rreg();
        return ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
    endfunction

    // Encoder model: pick an operation and operands, build the word and its expected decode.
    function automatic void gen(output logic [31:0] ins, output exp_t e);
        int k, f, v;
        logic [4:0] a, b, d;
        logic [31:0] im;
        logic [19:0] u;
        logic [11:0] csr;
        k = $urandom_range(0, 10);
        d = rreg(); a = rreg(); b = rreg();
        e = blank($urandom);
        case (k)
            0: begin
                f = $urandom_range(0, 9);
                ins = {(f == 1 || f == 7) ? 7'h20 : 7'h00, b, a, R_F3[f], d, 7'h33};
                e.op = R_OPS[f]; e.rd = d; e.rs1 = a; e.rs2 = b; e.r1 = 1; e.r2 = 1;
            end
            1, 3, 8: begin
                f = (k == 1) ? $urandom_range(0, 5) : (k == 3) ? $urandom_range(0, 4) : 0;
                v = $urandom_range(0, 4095) - 2048; im = v;
                ins = {im[11:0], a, (k == 1) ? I_F3[f] : (k == 3) ? L_F3[f] : 3'd0, d,
                       (k == 1) ? 7'h13 : (k == 3) ? 7'h03 : 7'h67};
                e.op = (k == 1) ? I_OPS[f] : (k == 3) ? L_OPS[f] : JALR;
                e.rd = d; e.rs1 = a; e.imm = im; e.imm_used = 1; e.r1 = 1;
            end
            2: begin
                f = $urandom_range(0, 2); v = $urandom_range(0, 31); im = v;
                ins = {(f == 2) ? 7'h20 : 7'h00, im[4:0], a, (f == 0) ? 3'd1 : 3'd5, d, 7'h13};
                e.op = SH_OPS[f]; e.rd = d; e.rs1 = a; e.imm = im; e.imm_used = 1; e.r1 = 1;
            end
            4: begin
                f = $urandom_range(0, 2); v = $urandom_range(0, 4095) - 2048; im = v;
                ins = {im[11:5], b, a, 3'(f), im[4:0], 7'h23};
                e.op = S_OPS[f]; e.rs1 = a; e.rs2 = b; e.imm = im; e.imm_used = 1;
                e.r1 = 1; e.r2 = 1;
            end
            5: begin
                f = $urandom_range(0, 5); v = ($urandom_range(0, 4095) - 2048) * 2; im = v;
                ins = {im[12], im[10:5], b, a, B_F3[f], im[4:1], im[11], 7'h63};
                e.op = B_OPS[f]; e.rs1 = a; e.rs2 = b; e.imm = im; e.imm_used = 1;
                e.r1 = 1; e.r2 = 1;
            end
            6: begin
                u = 20'($urandom); f = $urandom_range(0, 1);
                ins = {u, d, (f == 1) ? 7'h37 : 7'h17};
                e.op = (f == 1) ? LUI : AUIPC; e.rd = d; e.imm = {u, 12'h000}; e.imm_used = 1;
            end
            7: begin
                v = ($urandom_range(0, 1048575) - 524288) * 2; im = v;
                ins = {im[20], im[10:1], im[11], im[19:12], d, 7'h6F};
                e.op = JAL; e.rd = d; e.imm = im; e.imm_used = 1;
            end
            9: begin
                f = $urandom_range(0, 5); csr = 12'($urandom);
                ins = {csr, a, C_F3[f], d, 7'h73};
                e.op = C_OPS[f]; e.rd = d;
                if (f < 3) begin e.rs1 = a; e.r1 = 1; end
                else begin e.imm = 32'(a); e.imm_used = 1; end
            end
            default: begin
                ins = $urandom; ins[1:0] = 2'($urandom_range(0, 2));
                e.illegal = 1; e.illegal16 = 1;
            end
        endcase
        if (k != 10) e.illegal16 = (e.rd >= 16) || (e.rs1 >= 16) || (e.rs2 >= 16);
    endfunction

    function automatic bit hz(input exp_t e);
        return ld_valid && (ld_rd != 5'd0) &&
               ((e.r1 && e.rs1 == ld_rd) || (e.r2 && e.rs2 == ld_rd));
    endfunction

    always @(negedge clk) begin
        bit ev;
        if (rst) begin
            chk("reset_outputs", {id_valid, if_ready, illegal, imm_used, op, rd, rs1, rs2, imm, pc_out}, '0);
`ifdef KAMUS_ID_PERF_EN
            chk("reset_counters", {stall_cnt, hazard_cnt}, '0);
            stall_m = '0; hazard_m = '0;
`endif
            q.delete();
            exp_ready = 1'b0;
        end else begin
            ev = (q.size() > 0) && !hz(q[0]);
            chk("if_ready", if_ready, exp_ready);
            chk("id_valid", id_valid, ev);
            chk("id_valid16", id_valid16, ev);
`ifdef KAMUS_ID_PERF_EN
            chk("stall_cnt", stall_cnt, stall_m);
            chk("hazard_cnt", hazard_cnt, hazard_m);
            if (ev && !ex_ready) stall_m++;
            if (q.size() > 0 && hz(q[0])) hazard_m++;
`endif
            if (id_valid && ev) begin
                chk("op", 128'(op), 128'(q[0].op));
                chk("regs", {rd, rs1, rs2}, {q[0].rd, q[0].rs1, q[0].rs2});
                chk("imm", {imm_used, imm}, {q[0].imm_used, q[0].imm});
                chk("pc", pc_out, q[0].pc);
                chk("illegal", illegal, q[0].illegal);
                chk("illegal_nregs16", illegal16, q[0].illegal16);
            end
            if (flush) q.delete();
            else begin
                if (ev && ex_ready) void'(q.pop_front());
                if (if_valid && exp_ready) begin q.push_back(cur_exp); accepted = 1'b1; end
            end
            exp_ready = (q.size() < 2);
        end
    end

    task automatic present(input logic [31:0] ins, input exp_t e);
        instr = ins; pc = e.pc; cur_exp = e; if_valid = 1'b1;
    endtask

    task automatic send(input logic [31:0] ins, input exp_t e);
        int n = 0;
        present(ins, e);
        accepted = 1'b0;
        do begin @(posedge clk); #1; n++; end while (!accepted && n < 50);
        if (!accepted) begin
            n_checks++;
            $display("FAIL send_timeout: instr %h not accepted within 50 cycles", ins);
        end
        if_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [31:0] ins;
        exp_t e;
        int n;
        idle(3);
        rst = 1'b0;
        idle(1);

        ex_ready = 1'b1;
        send(32'h0050_0093, mk(ADD, 1, 0, 0, 32'd5, 1, 0, 0, 1, 0, 32'h100));
        idle(3);

        ex_ready = 1'b0;
        send(32'h0050_0093, mk(ADD, 1, 0, 0, 32'd5, 1, 0, 0, 1, 0, 32'h104));
        send(32'hFFF0_0113, mk(ADD, 2, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 1, 0, 32'h108));
        idle(3);
        ex_ready = 1'b1;
        idle(4);

        ld_valid = 1'b1; ld_rd = 5'd5;
        send(32'h0062_81B3, mk(ADD, 3, 5, 6, 32'd0, 0, 0, 0, 1, 1, 32'h10C));
        idle(3);
        ld_valid = 1'b0;
        idle(3);

        ex_ready = 1'b0;
        send(32'h0050_0093, mk(ADD, 1, 0, 0, 32'd5, 1, 0, 0, 1, 0, 32'h200));
        send(32'hFFF0_0113, mk(ADD, 2, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 1, 0, 32'h204));
        present(32'h0062_81B3, mk(ADD, 3, 5, 6, 32'd0, 0, 0, 0, 1, 1, 32'h208));
        flush = 1'b1;
        idle(1);
        flush = 1'b0; if_valid = 1'b0;
        idle(2);
        ex_ready = 1'b1;
        idle(2);

        send(32'h0000_0000, mk(INVALID, 0, 0, 0, 32'd0, 0, 1, 1, 0, 0, 32'h300));
        send(32'h0010_0893, mk(ADD, 17, 0, 0, 32'd1, 1, 0, 1, 1, 0, 32'h304));
        idle(3);

        for (int i = 0; i < 800; i++) begin
            gen(ins, e);
            instr = ins; pc = e.pc; cur_exp = e;
            if_valid = ($urandom_range(0, 1) == 1);
            ex_ready = ($urandom_range(0, 9) < 7);
            ld_valid = ($urandom_range(0, 9) < 3);
            ld_rd = 5'($urandom_range(0, 3));
            flush = ($urandom_range(0, 99) < 3);
            idle(1);
        end
        if_valid = 1'b0; flush = 1'b0; ld_valid = 1'b0; ex_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 100) begin idle(1); n++; end
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", q.size());
        end

        ex_ready = 1'b0;
        send(32'h0050_0093, mk(ADD, 1, 0, 0, 32'd5, 1, 0, 0, 1, 0, 32'h400));
        send(32'hFFF0_0113, mk(ADD, 2, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 1, 0, 32'h404));
        idle(2);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        idle(2);

        send(32'h0050_0093, mk(ADD, 1, 0, 0, 32'd5, 1, 0, 0, 1, 0, 32'h500));
        rst = 1'b1; flush = 1'b1; if_valid = 1'b1;
        idle(1);
        rst = 1'b0; flush = 1'b0; if_valid = 1'b0;
        idle(2);
        ex_ready = 1'b1;
        send(32'hFFF0_0113, mk(ADD, 2, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 1, 0, 32'h600));
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
